// File: rtl/tank_city_pkg.sv
// Types shared by the wall table, the overlap comparator and the query arbiter.
package tank_city_pkg;

    localparam int TILE_SHIFT = 4;
    localparam int COORD_W    = 6;
    localparam int PIX_W      = 10;

    typedef struct packed {
        logic [COORD_W-1:0] xcoord;
        logic [COORD_W-1:0] ycoord;
        logic [COORD_W-1:0] xsize;
        logic [COORD_W-1:0] ysize;
        logic               valid;
    } wall_entry_t;

    typedef enum logic [1:0] {IDLE, SCAN, RESP} arb_state_t;

endpackage

// File: rtl/wall_overlap.sv
// Converts one wall entry from tiles to pixels and tests it against a query
// rectangle; end points are carried in PIX_W+1 bits so nothing wraps.
module wall_overlap
    import tank_city_pkg::*;
(
    input  wall_entry_t      entry_i,
    input  logic [PIX_W-1:0] qx_i,
    input  logic [PIX_W-1:0] qy_i,
    input  logic [PIX_W-1:0] qw_i,
    input  logic [PIX_W-1:0] qh_i,
    output logic             hit_o
);

    logic [PIX_W-1:0] wx, wy, ww, wh;
    logic [PIX_W:0]   wx_end, wy_end, qx_end, qy_end;
    logic             nonempty;

    assign wx = PIX_W'(entry_i.xcoord) << TILE_SHIFT;
    assign wy = PIX_W'(entry_i.ycoord) << TILE_SHIFT;
    assign ww = PIX_W'(entry_i.xsize)  << TILE_SHIFT;
    assign wh = PIX_W'(entry_i.ysize)  << TILE_SHIFT;

    assign wx_end = {1'b0, wx}   + {1'b0, ww};
    assign wy_end = {1'b0, wy}   + {1'b0, wh};
    assign qx_end = {1'b0, qx_i} + {1'b0, qw_i};
    assign qy_end = {1'b0, qy_i} + {1'b0, qh_i};

    // Degenerate rectangles can still satisfy the strict compares, so reject them explicitly.
    assign nonempty = entry_i.valid && (ww != '0) && (wh != '0) &&
                      (qw_i != '0) && (qh_i != '0);

    assign hit_o = nonempty &&
                   ({1'b0, qx_i} < wx_end) && ({1'b0, wx} < qx_end) &&
                   ({1'b0, qy_i} < wy_end) && ({1'b0, wy} < qy_end);

endmodule

// File: rtl/wall_collision_arbiter.sv
// Wall table owner: round-robin arbitration of overlap queries, each scanning
// the table one entry per cycle through a single shared comparator.
module wall_collision_arbiter
    import tank_city_pkg::*;
#(
    parameter  int NUM_WALLS = 16,
    parameter  int NUM_REQ   = 4,
    localparam int IW        = $clog2(NUM_WALLS),
    localparam int RW        = $clog2(NUM_REQ)
)(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic [IW-1:0]                 wr_idx_i,
    input  logic [COORD_W-1:0]            wr_xcoord_i,
    input  logic [COORD_W-1:0]            wr_ycoord_i,
    input  logic [COORD_W-1:0]            wr_xsize_i,
    input  logic [COORD_W-1:0]            wr_ysize_i,
    input  logic                          clr_en_i,
    input  logic [IW-1:0]                 clr_idx_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0][PIX_W-1:0] q_x_i,
    input  logic [NUM_REQ-1:0][PIX_W-1:0] q_y_i,
    input  logic [NUM_REQ-1:0][PIX_W-1:0] q_w_i,
    input  logic [NUM_REQ-1:0][PIX_W-1:0] q_h_i,
    output logic [NUM_REQ-1:0]            ack_o,
    output logic                          hit_o,
    output logic [IW-1:0]                 hit_idx_o,
    output logic                          busy_o
);

    wall_entry_t      table_q [NUM_WALLS];
    arb_state_t       state_q, state_d;
    logic [RW-1:0]    rr_q, rr_d, id_q, id_d;
    logic [IW-1:0]    idx_q, idx_d, hit_idx_q, hit_idx_d;
    logic             hit_q, hit_d;
    logic [PIX_W-1:0] qx_q, qx_d, qy_q, qy_d, qw_q, qw_d, qh_q, qh_d;
    logic             gnt_vld;
    logic [RW-1:0]    gnt_id;
    logic [RW:0]      cand;
    logic             ovl_hit;

    // Write beats clear when both target the same entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_WALLS; i++) table_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_WALLS; i++) begin
                if (wr_en_i && wr_idx_i == IW'(i))
                    table_q[i] <= '{xcoord: wr_xcoord_i, ycoord: wr_ycoord_i,
                                    xsize:  wr_xsize_i,  ysize:  wr_ysize_i,
                                    valid:  1'b1};
                else if (clr_en_i && clr_idx_i == IW'(i))
                    table_q[i].valid <= 1'b0;
            end
        end
    end

    // First requester at or after rr_q, wrapping around.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (RW+1)'(k);
            if (cand >= (RW+1)'(NUM_REQ)) cand = cand - (RW+1)'(NUM_REQ);
            if (!gnt_vld && req_i[cand[RW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = cand[RW-1:0];
            end
        end
    end

    wall_overlap u_ovl (
        .entry_i (table_q[idx_q]),
        .qx_i    (qx_q),
        .qy_i    (qy_q),
        .qw_i    (qw_q),
        .qh_i    (qh_q),
        .hit_o   (ovl_hit)
    );

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        id_d      = id_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        qx_d      = qx_q;
        qy_d      = qy_q;
        qw_d      = qw_q;
        qh_d      = qh_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    id_d    = gnt_id;
                    qx_d    = q_x_i[gnt_id];
                    qy_d    = q_y_i[gnt_id];
                    qw_d    = q_w_i[gnt_id];
                    qh_d    = q_h_i[gnt_id];
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (ovl_hit) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                    state_d   = RESP;
                end else if (idx_q == IW'(NUM_WALLS-1)) begin
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                    state_d   = RESP;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            RESP: begin
                rr_d    = (id_q == RW'(NUM_REQ-1)) ? '0 : id_q + RW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            id_q      <= '0;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            qx_q      <= '0;
            qy_q      <= '0;
            qw_q      <= '0;
            qh_q      <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            id_q      <= id_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
            qx_q      <= qx_d;
            qy_q      <= qy_d;
            qw_q      <= qw_d;
            qh_q      <= qh_d;
        end
    end

    always_comb begin
        ack_o = '0;
        if (state_q == RESP) ack_o[id_q] = 1'b1;
    end

    assign hit_o     = hit_q;
    assign hit_idx_o = hit_idx_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_wall_collision_arbiter.sv
// Randomized and directed bench for wall_collision_arbiter against a
// transaction-level model of the wall table and query scheduling.
module tb_wall_collision_arbiter;

    localparam int NW = 16;
    localparam int NR = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wr_en, clr_en;
    logic [3:0]           wr_idx, clr_idx;
    logic [5:0]           wr_x, wr_y, wr_w, wr_h;
    logic [NR-1:0]        req;
    logic [NR-1:0][9:0]   qx, qy, qw, qh;
    logic [NR-1:0]        ack;
    logic                 hit, busy;
    logic [3:0]           hit_idx;

    always #5 clk = ~clk;

    wall_collision_arbiter #(.NUM_WALLS(NW), .NUM_REQ(NR)) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wr_idx_i(wr_idx),
        .wr_xcoord_i(wr_x), .wr_ycoord_i(wr_y), .wr_xsize_i(wr_w), .wr_ysize_i(wr_h),
        .clr_en_i(clr_en), .clr_idx_i(clr_idx),
        .req_i(req), .q_x_i(qx), .q_y_i(qy), .q_w_i(qw), .q_h_i(qh),
        .ack_o(ack), .hit_o(hit), .hit_idx_o(hit_idx), .busy_o(busy)
    );

    int n_checks = 0, n_fails = 0;
    int edge_cnt = 0, ack_cnt = 0;
    int last_id, last_hit, last_idx, last_edge;
    int ack_q[$];

    // Model: table contents, and the one query in flight (0 free, 1 scanning, 2 acking).
    int mt_x[NW], mt_y[NW], mt_w[NW], mt_h[NW];
    bit mt_v[NW];
    int m_st = 0, m_g, m_id, m_rr = 0, m_hit = 0, m_hidx = 0, m_k;
    int m_qx, m_qy, m_qw, m_qh;
    bit m_h;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit overlaps(input int i, input int x, input int y, input int w, input int h);
        int wx, wy, ww, wh;
        wx = mt_x[i] * 16; wy = mt_y[i] * 16;
        ww = mt_w[i] * 16; wh = mt_h[i] * 16;
        return mt_v[i] && ww > 0 && wh > 0 && w > 0 && h > 0 &&
               x < wx + ww && wx < x + w && y < wy + wh && wy < y + h;
    endfunction

    // Model step and comparison, just after each rising edge.
    always @(posedge clk) begin
        #1;
        edge_cnt++;
        if (rst) begin
            m_st = 0; m_rr = 0; m_hit = 0; m_hidx = 0;
            for (int i = 0; i < NW; i++) begin
                mt_v[i] = 0; mt_x[i] = 0; mt_y[i] = 0; mt_w[i] = 0; mt_h[i] = 0;
            end
        end else begin
            if (m_st == 0) begin
                for (int k = 0; k < NR; k++) begin
                    if (m_st == 0 && req[(m_rr + k) % NR]) begin
                        m_id = (m_rr + k) % NR;
                        m_st = 1;
                        m_g  = edge_cnt;
                        m_qx = qx[m_id]; m_qy = qy[m_id]; m_qw = qw[m_id]; m_qh = qh[m_id];
                    end
                end
            end else if (m_st == 1) begin
                // Entry k was examined in the cycle that just ended, against the table as it stood then.
                m_k = edge_cnt - m_g - 1;
                m_h = overlaps(m_k, m_qx, m_qy, m_qw, m_qh);
                if (m_h || m_k == NW - 1) begin
                    m_hit  = m_h;
                    m_hidx = m_h ? m_k : 0;
                    m_st   = 2;
                end
            end else begin
                m_rr = (m_id + 1) % NR;
                m_st = 0;
            end
            if (clr_en) mt_v[clr_idx] = 0;
            if (wr_en) begin
                mt_x[wr_idx] = wr_x; mt_y[wr_idx] = wr_y;
                mt_w[wr_idx] = wr_w; mt_h[wr_idx] = wr_h;
                mt_v[wr_idx] = 1;
            end
        end
        chk("ack", ack, (m_st == 2) ? (1 << m_id) : 0);
        chk("busy", busy, (m_st != 0) ? 1 : 0);
        if (m_st == 2) begin
            chk("hit", hit, m_hit);
            chk("hit_idx", hit_idx, m_hidx);
        end
        if (ack != '0) begin
            ack_cnt++;
            for (int r = 0; r < NR; r++) if (ack[r]) last_id = r;
            last_hit  = hit;
            last_idx  = hit_idx;
            last_edge = edge_cnt;
            ack_q.push_back(last_id);
        end
    end

    task automatic wr(input int i, input int x, input int y, input int w, input int h);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 4'(i);
        wr_x = 6'(x); wr_y = 6'(y); wr_w = 6'(w); wr_h = 6'(h);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic clr(input int i);
        @(negedge clk);
        clr_en = 1'b1; clr_idx = 4'(i);
        @(negedge clk);
        clr_en = 1'b0;
    endtask

    // Query from requester id; optional clear pulse during cycle clr_at counted from the request cycle.
    task automatic run_query(input int id, input int x, input int y, input int w, input int h,
                             input int eh, input int ei, input int elat,
                             input int clr_at, input int cidx);
        int e0, base;
        bit got;
        @(negedge clk);
        qx[id] = 10'(x); qy[id] = 10'(y); qw[id] = 10'(w); qh[id] = 10'(h);
        req[id] = 1'b1;
        e0 = edge_cnt; base = ack_cnt; got = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            clr_en  = (clr_at >= 0 && edge_cnt - e0 == clr_at);
            clr_idx = 4'(cidx);
            if (ack_cnt != base) begin
                got = 1;
                req[id] = 1'b0;
            end
        end
        clr_en = 1'b0;
        if (!got) begin
            n_checks++; n_fails++;
            $display("FAIL query_timeout: no ack for requester %0d", id);
            req[id] = 1'b0;
        end else begin
            chk("q_latency", last_edge - e0, elat);
            chk("q_ack_id", last_id, id);
            chk("q_hit", last_hit, eh);
            chk("q_hit_idx", last_idx, ei);
        end
    endtask

    initial begin
        int exp_ord[5];
        int base;
        exp_ord = '{0, 1, 2, 3, 0};
        rst = 1'b1; wr_en = 1'b0; clr_en = 1'b0; wr_idx = '0; clr_idx = '0;
        wr_x = '0; wr_y = '0; wr_w = '0; wr_h = '0;
        req = '0; qx = '0; qy = '0; qw = '0; qh = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_hit", hit, 0);
        chk("rst_hit_idx", hit_idx, 0);

        // Empty table, then single-wall hit and touching-edge miss.
        run_query(0, 0, 0, 16, 16, 0, 0, 17, -1, 0);
        wr(5, 2, 3, 1, 1);
        run_query(1, 40, 50, 4, 4, 1, 5, 7, -1, 0);
        run_query(1, 48, 48, 8, 8, 0, 0, 17, -1, 0);
        run_query(1, 40, 50, 0, 4, 0, 0, 17, -1, 0);

        // Lowest index wins; clearing it exposes the next.
        clr(5);
        wr(3, 2, 3, 1, 1);
        wr(9, 2, 3, 1, 1);
        run_query(2, 40, 50, 4, 4, 1, 3, 5, -1, 0);
        clr(3);
        run_query(2, 40, 50, 4, 4, 1, 9, 11, -1, 0);

        // Same-cycle write and clear: write wins.
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 4'd7; wr_x = 6'd10; wr_y = 6'd10; wr_w = 6'd1; wr_h = 6'd1;
        clr_en = 1'b1; clr_idx = 4'd7;
        @(negedge clk);
        wr_en = 1'b0; clr_en = 1'b0;
        run_query(3, 160, 160, 1, 1, 1, 7, 9, -1, 0);
        // Clear lands in the cycle entry 7 is tested: still a hit, then gone.
        run_query(0, 160, 160, 1, 1, 1, 7, 9, 8, 7);
        run_query(0, 160, 160, 1, 1, 0, 0, 17, -1, 0);

        // Zero-size wall never hits; large wall needs the 11-bit end point.
        wr(11, 20, 20, 0, 2);
        run_query(1, 316, 316, 8, 8, 0, 0, 17, -1, 0);
        wr(15, 63, 63, 63, 63);
        run_query(2, 1000, 1000, 20, 20, 1, 15, 17, -1, 0);
        run_query(3, 1023, 1023, 1023, 1023, 1, 15, 17, -1, 0);

        // Reset in the middle of a scan: no ack, table emptied.
        @(negedge clk);
        qx[1] = 10'd40; qy[1] = 10'd50; qw[1] = 10'd4; qh[1] = 10'd4;
        req[1] = 1'b1;
        base = ack_cnt;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0; req[1] = 1'b0;
        repeat (25) @(negedge clk);
        chk("rst_mid_no_ack", ack_cnt - base, 0);
        run_query(1, 40, 50, 4, 4, 0, 0, 17, -1, 0);

        // All requesters held from reset: strict rotation.
        @(negedge clk);
        rst = 1'b1; req = '1;
        for (int r = 0; r < NR; r++) begin
            qx[r] = 10'd0; qy[r] = 10'd0; qw[r] = 10'd8; qh[r] = 10'd8;
        end
        @(negedge clk);
        rst = 1'b0;
        ack_q.delete();
        for (int t = 0; t < 200 && ack_q.size() < 5; t++) @(negedge clk);
        req = '0;
        if (ack_q.size() < 5) begin
            n_checks++; n_fails++;
            $display("FAIL rr_timeout: got %0d acks expected 5", ack_q.size());
        end else begin
            for (int i = 0; i < 5; i++) chk("rr_order", ack_q[i], exp_ord[i]);
        end

        // Random traffic: writes, clears, held requests, mid-scan input noise.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            wr_en = ($urandom_range(0, 3) == 0);
            wr_idx = 4'($urandom_range(0, NW - 1));
            wr_x = 6'($urandom_range(0, 20)); wr_y = 6'($urandom_range(0, 20));
            wr_w = 6'($urandom_range(0, 4));  wr_h = 6'($urandom_range(0, 4));
            clr_en = ($urandom_range(0, 5) == 0);
            clr_idx = 4'($urandom_range(0, NW - 1));
            for (int r = 0; r < NR; r++) begin
                if (ack[r]) req[r] = 1'b0;
                else if (!req[r] && $urandom_range(0, 7) == 0) begin
                    req[r] = 1'b1;
                    qx[r] = 10'($urandom_range(0, 400)); qy[r] = 10'($urandom_range(0, 400));
                    qw[r] = 10'($urandom_range(0, 64));  qh[r] = 10'($urandom_range(0, 64));
                end else if (req[r] && $urandom_range(0, 15) == 0) begin
                    qx[r] = 10'($urandom_range(0, 400)); qy[r] = 10'($urandom_range(0, 400));
                end else if (req[r] && $urandom_range(0, 63) == 0) begin
                    req[r] = 1'b0;
                end
            end
        end
        @(negedge clk);
        wr_en = 1'b0; clr_en = 1'b0; req = '0;
        for (int t = 0; t < 40 && busy; t++) @(negedge clk);
        chk("final_idle", busy, 0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
